// File: rtl/wbm_pkg.sv
// Shared types for the Wishbone host master: FSM state encoding,
// the default-width command record and its byte-enable width.
package wbm_pkg;

  localparam int WBM_AW = 32;
  localparam int WBM_DW = 32;
  localparam int SELW   = WBM_DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } wbm_state_t;

  typedef struct packed {
    logic              we;
    logic [WBM_AW-1:0] adr;
    logic [WBM_DW-1:0] dat;
    logic [SELW-1:0]   sel;
  } wbm_cmd_t;

endpackage

// File: rtl/wbm_watchdog.sv
// Bus-cycle watchdog: counts cycles spent waiting for ACK and flags
// expiry in the last allowed cycle. Only instantiated when the host master
// is built with WBM_TIMEOUT_EN.
module wbm_watchdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // Restart on each new transfer, then count waiting cycles, holding at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone B4 classic single-transfer initiator. Takes one command at a time
// from a valid/ready stream, runs one read or write on the bus, and returns
// the result on a valid/ready response stream.
// Build option: define WBM_TIMEOUT_EN to abort transfers that receive no ACK
// within TIMEOUT_CYC strobe cycles (response then carries rsp_err_o=1).
module wb_host_master
  import wbm_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i,
  output logic            busy_o
);

  localparam int SW = DW / 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } cmd_t;

  wbm_state_t    state;
  cmd_t          cmd_q;
  logic          cyc_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_dat_q;
  logic          rsp_err_q;
  logic          accept;
  logic          expired;

  assign cmd_ready_o = (state == IDLE) && wb_rst_ni;
  assign accept      = cmd_valid_i && cmd_ready_o;

`ifdef WBM_TIMEOUT_EN
  wbm_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (accept),
    .enable  (state == REQ),
    .expired (expired)
  );
`else
  // Without the watchdog a transfer waits for ACK forever; the limit is only
  // referenced here so the parameter list stays identical in both builds.
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign expired = 1'b0;
`endif

  // Transfer FSM: capture command, hold the bus until ACK (or watchdog expiry), then hold the response until consumed.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      cmd_q       <= '0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q.we  <= cmd_we_i;
            cmd_q.adr <= cmd_adr_i;
            cmd_q.dat <= cmd_dat_i;
            cmd_q.sel <= cmd_sel_i;
            cyc_q     <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (wbm_ack_i) begin
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= cmd_q.we ? '0 : wbm_dat_i;
            rsp_err_q   <= 1'b0;
            state       <= RESP;
          end else if (expired) begin
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          cyc_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = cmd_q.we;
  assign wbm_adr_o   = cmd_q.adr;
  assign wbm_dat_o   = cmd_q.dat;
  assign wbm_sel_o   = cmd_q.sel;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master. Honours WBM_TIMEOUT_EN
// for the no-ACK scenario.
module tb_wb_host_master;
  import wbm_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [31:0] wbm_adr;
  logic [31:0] wbm_dat_out;
  logic [3:0]  wbm_sel;
  logic        wbm_ack;
  logic [31:0] wbm_dat_in;
  logic        busy;

  int total = 0;
  int bad   = 0;

  wb_host_master #(
    .AW          (32),
    .DW          (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_out),
    .wbm_sel_o   (wbm_sel),
    .wbm_ack_i   (wbm_ack),
    .wbm_dat_i   (wbm_dat_in),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input wbm_cmd_t c);
    cmd_valid = 1'b1;
    cmd_we    = c.we;
    cmd_adr   = c.adr;
    cmd_dat   = c.dat;
    cmd_sel   = c.sel;
  endtask

  task automatic dropCommand();
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
  endtask

  // Plays the responder: starts in a strobe cycle, acks in strobe cycle waitCyc+1,
  // and checks that the bus request stays stable while waiting.
  task automatic serveBus(input wbm_cmd_t c, input int waitCyc, input logic [31:0] rd,
                          output int stbCycles);
    stbCycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!wbm_stb) break;
      stbCycles++;
      checkOutput("bus_we",  {63'h0, wbm_we}, {63'h0, c.we});
      checkOutput("bus_adr", {32'h0, wbm_adr}, {32'h0, c.adr});
      checkOutput("bus_sel", {60'h0, wbm_sel}, {60'h0, c.sel});
      if (c.we) checkOutput("bus_dat", {32'h0, wbm_dat_out}, {32'h0, c.dat});
      wbm_ack    = (stbCycles == waitCyc + 1);
      wbm_dat_in = wbm_ack ? rd : 32'hDEAD_BEEF;
      tick();
    end
    wbm_ack    = 1'b0;
    wbm_dat_in = 32'h0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    wbm_cmd_t c;
    wbm_cmd_t c2;
    int       n;
    int       seen;

    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    wbm_ack    = 1'b0;
    wbm_dat_in = 32'h0;
    dropCommand();
    tick();
    tick();

    checkOutput("rst_cyc",       {63'h0, wbm_cyc},   64'h0);
    checkOutput("rst_stb",       {63'h0, wbm_stb},   64'h0);
    checkOutput("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    checkOutput("rst_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    checkOutput("rst_busy",      {63'h0, busy},      64'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_cmd_ready", {63'h0, cmd_ready}, 64'h1);

    // Test 1: write with two wait states
    c = '{we: 1'b1, adr: 32'h3000_0004, dat: 32'hA5A5_1234, sel: 4'hF};
    applyStimulus(c);
    tick();
    dropCommand();
    checkOutput("t1_stb_rise",  {63'h0, wbm_stb},   64'h1);
    checkOutput("t1_cyc_rise",  {63'h0, wbm_cyc},   64'h1);
    checkOutput("t1_busy",      {63'h0, busy},      64'h1);
    checkOutput("t1_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    serveBus(c, 2, 32'h0, n);
    checkOutput("t1_stb_cycles", 64'(n),             64'd3);
    checkOutput("t1_cyc_drop",   {63'h0, wbm_cyc},   64'h0);
    checkOutput("t1_rsp_valid",  {63'h0, rsp_valid}, 64'h1);
    checkOutput("t1_rsp_err",    {63'h0, rsp_err},   64'h0);
    checkOutput("t1_rsp_dat",    {32'h0, rsp_dat},   64'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("t1_rsp_done",  {63'h0, rsp_valid}, 64'h0);
    checkOutput("t1_idle",      {63'h0, cmd_ready}, 64'h1);

    // Test 2: read with zero-wait-state ack
    c = '{we: 1'b0, adr: 32'h3000_0000, dat: 32'h0, sel: 4'hF};
    applyStimulus(c);
    tick();
    dropCommand();
    serveBus(c, 0, 32'hCAFE_F00D, n);
    checkOutput("t2_stb_cycles", 64'(n),             64'd1);
    checkOutput("t2_rsp_valid",  {63'h0, rsp_valid}, 64'h1);
    checkOutput("t2_rsp_dat",    {32'h0, rsp_dat},   64'hCAFE_F00D);
    checkOutput("t2_rsp_err",    {63'h0, rsp_err},   64'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Test 3: back-to-back commands with the response always consumed
    c  = '{we: 1'b0, adr: 32'h3000_0008, dat: 32'h0,         sel: 4'hF};
    c2 = '{we: 1'b1, adr: 32'h3000_000C, dat: 32'h55AA_55AA, sel: 4'h3};
    rsp_ready = 1'b1;
    applyStimulus(c);
    tick();
    applyStimulus(c2);
    serveBus(c, 0, 32'h1111_2222, n);
    checkOutput("t3_a_stb_cycles", 64'(n),             64'd1);
    checkOutput("t3_a_rsp_valid",  {63'h0, rsp_valid}, 64'h1);
    checkOutput("t3_a_rsp_dat",    {32'h0, rsp_dat},   64'h1111_2222);
    checkOutput("t3_a_cmd_ready",  {63'h0, cmd_ready}, 64'h0);
    tick();
    checkOutput("t3_gap_cyc",       {63'h0, wbm_cyc},   64'h0);
    checkOutput("t3_gap_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    checkOutput("t3_gap_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    tick();
    dropCommand();
    checkOutput("t3_b_stb_rise", {63'h0, wbm_stb}, 64'h1);
    serveBus(c2, 1, 32'h0, n);
    checkOutput("t3_b_stb_cycles", 64'(n),             64'd2);
    checkOutput("t3_b_rsp_valid",  {63'h0, rsp_valid}, 64'h1);
    checkOutput("t3_b_rsp_dat",    {32'h0, rsp_dat},   64'h0);
    tick();
    rsp_ready = 1'b0;
    checkOutput("t3_b_rsp_done",   {63'h0, rsp_valid}, 64'h0);

    // Test 4: response backpressure with a stray ack and a pending command
    c  = '{we: 1'b0, adr: 32'h3000_0010, dat: 32'h0,         sel: 4'hF};
    c2 = '{we: 1'b1, adr: 32'h3000_0014, dat: 32'h7777_7777, sel: 4'h1};
    applyStimulus(c);
    tick();
    dropCommand();
    serveBus(c, 1, 32'h0BAD_CAFE, n);
    checkOutput("t4_stb_cycles", 64'(n), 64'd2);
    applyStimulus(c2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_hold_valid",     {63'h0, rsp_valid}, 64'h1);
      checkOutput("t4_hold_dat",       {32'h0, rsp_dat},   64'h0BAD_CAFE);
      checkOutput("t4_hold_err",       {63'h0, rsp_err},   64'h0);
      checkOutput("t4_hold_cmd_ready", {63'h0, cmd_ready}, 64'h0);
      checkOutput("t4_hold_cyc",       {63'h0, wbm_cyc},   64'h0);
      wbm_ack    = (i == 2);
      wbm_dat_in = (i == 2) ? 32'hFFFF_0000 : 32'h0;
      tick();
    end
    wbm_ack    = 1'b0;
    wbm_dat_in = 32'h0;
    dropCommand();
    checkOutput("t4_after_valid", {63'h0, rsp_valid}, 64'h1);
    checkOutput("t4_after_dat",   {32'h0, rsp_dat},   64'h0BAD_CAFE);
    checkOutput("t4_adr_kept",    {32'h0, wbm_adr},   64'h3000_0010);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("t4_rsp_done", {63'h0, rsp_valid}, 64'h0);
    checkOutput("t4_not_busy", {63'h0, busy},      64'h0);

    // Test 6: reset during the third request cycle
    c = '{we: 1'b1, adr: 32'h3000_0018, dat: 32'h1234_5678, sel: 4'hF};
    applyStimulus(c);
    tick();
    dropCommand();
    tick();
    tick();
    checkOutput("t6_pre_stb", {63'h0, wbm_stb}, 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_cyc",       {63'h0, wbm_cyc},   64'h0);
    checkOutput("t6_rst_stb",       {63'h0, wbm_stb},   64'h0);
    checkOutput("t6_rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    checkOutput("t6_rst_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    checkOutput("t6_rst_adr",       {32'h0, wbm_adr},   64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("t6_rel_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    checkOutput("t6_rel_busy",      {63'h0, busy},      64'h0);
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || wbm_cyc) seen++;
      tick();
    end
    rsp_ready = 1'b0;
    checkOutput("t6_no_response", 64'(seen), 64'd0);

    // Test 5: no ack ever arrives
    c = '{we: 1'b0, adr: 32'h3000_0020, dat: 32'h0, sel: 4'hF};
    applyStimulus(c);
    tick();
    dropCommand();
`ifdef WBM_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!wbm_stb) break;
      n++;
      tick();
    end
    checkOutput("t5_stb_cycles", 64'(n),             64'd8);
    checkOutput("t5_cyc_drop",   {63'h0, wbm_cyc},   64'h0);
    checkOutput("t5_rsp_valid",  {63'h0, rsp_valid}, 64'h1);
    checkOutput("t5_rsp_err",    {63'h0, rsp_err},   64'h1);
    checkOutput("t5_rsp_dat",    {32'h0, rsp_dat},   64'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("t5_rsp_done",   {63'h0, rsp_valid}, 64'h0);
    checkOutput("t5_err_clear",  {63'h0, rsp_err},   64'h0);
`else
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (wbm_cyc) n++;
      tick();
    end
    checkOutput("t5_cyc_held",   64'(n),             64'd100);
    checkOutput("t5_no_rsp",     {63'h0, rsp_valid}, 64'h0);
    checkOutput("t5_err_tied",   {63'h0, rsp_err},   64'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("t5_recover",    {63'h0, cmd_ready}, 64'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
